keypad_scan_multi: RTL and testbench
====================================

# keypad_scan_multi

Parametrised successor to the two-line patient button/pedal scanner. It strobes CHANNELS serial key lines once per scan period and samples a BITS-wide frame from each line. A frame is accepted only after edge-count validation and DEBOUNCE consecutive identical frames. Changes to the committed key map are queued as press/release event codes in a FIFO with a ready/valid handshake, so no event is lost to a slow consumer until the FIFO is full.

## Interface
- CHANNELS, 2, number of strobe/data line pairs (1..8)
- BITS, 5, frame bits sampled per channel (2..7)
- SCAN_PERIOD, 1000, clk cycles per scan
- STROBE_LEN, 8, cycles the strobe is held low at scan start
- FIRST_SAMPLE, 22, scan-counter value of the first sample
- SLOT, 11, cycles between samples
- DEBOUNCE, 2, identical validated frames required before commit (1..15)
- FIFO_DEPTH, 4, event FIFO entries (power of two)
- CODE_BASE, 39, base of the 6-bit key number; must satisfy K-1 <= CODE_BASE <= 63
- clk  in  1  system clock, 1 MHz nominal
- rst  in  1  reset, synchronous, active-high
- scan_line  out  CHANNELS  strobe lines, active low
- data_line  in  CHANNELS  serial key data, asynchronous
- key_state  out  K=CHANNELS*BITS  committed key map (1 = released)
- evt_valid  out  1  FIFO head valid
- evt_code  out  8  FIFO head event code
- evt_ready  in  1  consumer accepts head
- frame_err  out  CHANNELS  one-cycle pulse per rejected frame
- overflow  out  1  sticky: an event was dropped
- overflow_clr  in  1  clears overflow

## Operation
- Values after reset: scan_line all 1, key_state all 1, evt_valid 0, evt_code 0, frame_err 0, overflow 0. The scan counter sc, FIFO, debounce counters and edge counters are 0.
- sc counts 0..SCAN_PERIOD-1 and wraps. All channels share sc.
- scan_line[c] = 0 while sc < STROBE_LEN, and 1 otherwise.
- data_line passes through a 2-flop synchroniser. The names d[c] and all sampling below refer to the synchronised value.
- Samples: at sc = FIRST_SAMPLE + i*SLOT, i = 0..BITS-1, the block stores d[c] into frame bit BITS-1-i (MSB first).
- Edge counter per channel: counts 1→0 transitions of d[c] while scan_line[c] = 1 and sc < E, where E = FIRST_SAMPLE+(BITS-1)*SLOT+1. The counter saturates at 7 and is cleared while scan_line[c] = 0.
- Evaluation at sc = E. A frame is valid if edges == BITS, or if edges == 0 and the frame is all 1 (idle line). Otherwise frame_err[c] pulses and the debounce counter is cleared.
- Debounce per channel: a valid frame equal to the previous valid frame increments the counter, saturating at DEBOUNCE. A valid frame that differs loads the counter with 1. When the counter reaches DEBOUNCE, the frame is committed to key_state[c*BITS +: BITS].
- Event scan: from sc = E+1, the block visits key index k = 0..K-1 at one index per cycle. Key k is frame bit b of channel c, with k = c*BITS+b. If the committed bit differs from its value before this scan's commit, the block pushes an event. evt_code[7:6] = 2'b10 if the new bit is 1 (release) and 2'b01 if it is 0 (press). evt_code[5:0] = CODE_BASE-k.
- FIFO: a push when the FIFO is full drops the event and sets overflow. A push and a pop in the same cycle are both allowed when the FIFO is full.
- Handshake: the head is popped when evt_valid && evt_ready. evt_code stays stable while evt_valid=1 and evt_ready=0.
- overflow_clr clears overflow. If overflow_clr and a drop occur in the same cycle, the set wins.
- Constraint: E+K < SCAN_PERIOD and STROBE_LEN <= FIRST_SAMPLE.

## Timing
- Input-to-sample latency: 2 cycles (synchroniser).
- Event latency: for key k committed at scan evaluation E, evt_valid rises at sc = E+2+k when the FIFO was empty.
- Minimum press-to-event time: DEBOUNCE scan periods.
- The FIFO output is registered. The first event is visible 1 cycle after its push. Throughput is 1 event per cycle.
- Reset mid-scan: on the next cycle everything returns to its reset values. This includes the FIFO contents, and pending events are discarded.

## Test plan
- Idle lines held at 1, 3 scans -> no frame_err, no events, key_state all 1.
- Channel 0 driven with 5 low pulses encoding frame 5'b11110, DEBOUNCE=2, 2 scans -> one event 8'h67 (press, key 0 → 39-0=39). It appears at sc = 69 of the second scan.
- Release of the same key on the following 2 scans -> event 8'hA7.
- Only 3 edges in a frame -> frame_err[0] pulse at sc = 67, debounce counter reset, no event.
- evt_ready held 0, 10 key changes in one scan with FIFO_DEPTH=4 -> 4 events retained, overflow=1. After evt_ready is asserted, the retained events drain in key-index order. overflow_clr then clears the flag.
- rst asserted at sc = 40 with 2 events queued -> evt_valid=0 and scan_line=all 1 next cycle, sc restarts at 0.

Source files
------------

// File: rtl/keypad_scan_multi.sv
// Multi-channel serial keypad scanner: strobes CHANNELS key lines every scan period, validates and
// debounces each sampled frame, and queues press/release codes for committed key changes in an event FIFO.
module keypad_scan_multi #(
    parameter int CHANNELS     = 2,
    parameter int BITS         = 5,
    parameter int SCAN_PERIOD  = 1000,
    parameter int STROBE_LEN   = 8,
    parameter int FIRST_SAMPLE = 22,
    parameter int SLOT         = 11,
    parameter int DEBOUNCE     = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int CODE_BASE    = 39
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [CHANNELS-1:0]      scan_line,
    input  logic [CHANNELS-1:0]      data_line,
    output logic [CHANNELS*BITS-1:0] key_state,
    output logic                     evt_valid,
    output logic [7:0]               evt_code,
    input  logic                     evt_ready,
    output logic [CHANNELS-1:0]      frame_err,
    output logic                     overflow,
    input  logic                     overflow_clr
);
    localparam int K   = CHANNELS * BITS;
    localparam int E   = FIRST_SAMPLE + (BITS - 1) * SLOT + 1;
    localparam int SCW = $clog2(SCAN_PERIOD);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int KW  = $clog2(K);

    localparam logic [SCW-1:0] SC_LAST   = SCW'(SCAN_PERIOD - 1);
    localparam logic [SCW-1:0] SC_STROBE = SCW'(STROBE_LEN);
    localparam logic [SCW-1:0] SC_EVAL   = SCW'(E - 1);
    localparam logic [SCW-1:0] SC_E      = SCW'(E);
    localparam logic [SCW-1:0] SC_EV0    = SCW'(E + 1);
    localparam logic [SCW-1:0] SC_EVEND  = SCW'(E + 1 + K);
    localparam logic [3:0]     DB        = 4'(DEBOUNCE);

    logic [SCW-1:0]      sc, scNxt;
    logic [CHANNELS-1:0] sync1, sync2, dPrev, frameOk;
    logic [BITS-1:0]     frame [CHANNELS];
    logic [BITS-1:0]     frameNxt [CHANNELS];
    logic [BITS-1:0]     prevFrame [CHANNELS];
    logic [2:0]          edges [CHANNELS];
    logic [2:0]          edgeNxt [CHANNELS];
    logic [3:0]          dbCnt [CHANNELS];
    logic [3:0]          dbNxt [CHANNELS];
    logic [K-1:0]        keyOld;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wrPtr, rdPtr, rdNxt;
    logic [CW-1:0]       count, countNxt;
    logic [KW-1:0]       kIdx;
    logic [7:0]          pushCode;
    logic                inScan, pushReq, push, pop, full, drop;

    // Frame assembly, edge counting and the validation/debounce decision. The decision is taken on the
    // cycle of the last sample (sc = E-1) using the next-state values, so results are visible at sc = E.
    always_comb begin
        scNxt = (sc == SC_LAST) ? '0 : sc + SCW'(1);
        for (int c = 0; c < CHANNELS; c++) begin
            frameNxt[c] = frame[c];
            for (int i = 0; i < BITS; i++) begin
                if (sc == SCW'(FIRST_SAMPLE + i * SLOT)) frameNxt[c][BITS-1-i] = sync2[c];
            end
            edgeNxt[c] = edges[c];
            if (!scan_line[c]) edgeNxt[c] = 3'd0;
            else if (sc < SC_E && dPrev[c] && !sync2[c] && edges[c] != 3'd7) edgeNxt[c] = edges[c] + 3'd1;
            frameOk[c] = (edgeNxt[c] == 3'(BITS)) || (edgeNxt[c] == 3'd0 && (&frameNxt[c]));
            dbNxt[c] = 4'd0;
            if (frameOk[c]) begin
                if (frameNxt[c] != prevFrame[c]) dbNxt[c] = 4'd1;
                else if (dbCnt[c] >= DB)         dbNxt[c] = DB;
                else                             dbNxt[c] = dbCnt[c] + 4'd1;
            end
        end
    end

    // Event scan walks one key index per cycle and compares against the map snapshot taken before commit.
    always_comb begin
        inScan   = (sc >= SC_EV0) && (sc < SC_EVEND);
        kIdx     = KW'(sc - SC_EV0);
        pushReq  = inScan && (key_state[kIdx] != keyOld[kIdx]);
        pushCode = {key_state[kIdx] ? 2'b10 : 2'b01, 6'(CODE_BASE - int'(kIdx))};
        pop      = evt_valid && evt_ready;
        full     = (count == CW'(FIFO_DEPTH));
        push     = pushReq && (!full || pop);
        drop     = pushReq && full && !pop;
        countNxt = count;
        if (push && !pop)      countNxt = count + CW'(1);
        else if (!push && pop) countNxt = count - CW'(1);
        rdNxt = pop ? rdPtr + AW'(1) : rdPtr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sc        <= '0;
            scan_line <= '1;
            sync1     <= '1;
            sync2     <= '1;
            dPrev     <= '1;
            key_state <= '1;
            keyOld    <= '1;
            frame_err <= '0;
            overflow  <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                frame[c]     <= '1;
                prevFrame[c] <= '1;
                edges[c]     <= '0;
                dbCnt[c]     <= '0;
            end
        end else begin
            sc        <= scNxt;
            scan_line <= (scNxt < SC_STROBE) ? '0 : '1;
            sync1     <= data_line;
            sync2     <= sync1;
            dPrev     <= sync2;
            frame_err <= '0;
            if (sc == SC_EVAL) keyOld <= key_state;
            for (int c = 0; c < CHANNELS; c++) begin
                frame[c] <= frameNxt[c];
                edges[c] <= edgeNxt[c];
                if (sc == SC_EVAL) begin
                    dbCnt[c]     <= dbNxt[c];
                    frame_err[c] <= !frameOk[c];
                    if (frameOk[c]) prevFrame[c] <= frameNxt[c];
                    if (frameOk[c] && dbNxt[c] == DB) key_state[c*BITS +: BITS] <= frameNxt[c];
                end
            end
            if (push) begin
                mem[wrPtr] <= pushCode;
                wrPtr      <= wrPtr + AW'(1);
            end
            rdPtr     <= rdNxt;
            count     <= countNxt;
            evt_valid <= (countNxt != '0);
            // A push into an otherwise empty queue bypasses the memory read so the head shows it next cycle.
            if (countNxt != '0) evt_code <= (push && wrPtr == rdNxt) ? pushCode : mem[rdNxt];
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keypad_scan_multi.sv
// Directed bench for keypad_scan_multi: drives pulse-encoded frames on the key lines and checks
// committed key map, event codes/timing, frame errors, FIFO overflow and mid-scan reset.
module tb_keypad_scan_multi;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] scan_line, frame_err;
    logic [1:0] data_line = 2'b11;
    logic [9:0] key_state;
    logic       evt_valid, overflow;
    logic       evt_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [7:0] evt_code;

    int total = 0;
    int bad = 0;
    int tsc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] gotCode[$];
    int gotTsc[$];
    int err0Cnt = 0;
    int err1Cnt = 0;
    int err0Tsc = -1;

    keypad_scan_multi #(
        .CHANNELS(2), .BITS(5), .SCAN_PERIOD(1000), .STROBE_LEN(8), .FIRST_SAMPLE(22),
        .SLOT(11), .DEBOUNCE(2), .FIFO_DEPTH(4), .CODE_BASE(39)
    ) dut (
        .clk(clk), .rst(rst), .scan_line(scan_line), .data_line(data_line), .key_state(key_state),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready), .frame_err(frame_err),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    // Bench's own scan position, restarted by reset.
    always @(posedge clk) tsc <= rst ? 0 : ((tsc == 999) ? 0 : tsc + 1);

    always @(negedge clk) begin
        if (!rst) begin
            if (evt_valid && evt_ready) begin
                gotCode.push_back(evt_code);
                gotTsc.push_back(tsc);
            end
            if (frame_err[0]) begin
                err0Cnt++;
                err0Tsc = tsc;
            end
            if (frame_err[1]) err1Cnt++;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One low pulse per bit: a short pulse for a 1 bit, a pulse spanning the sample point for a 0 bit.
    function automatic logic lineLevel(input int s, input logic [4:0] f, input int p);
        logic lvl = 1'b1;
        for (int i = 0; i < p; i++) begin
            int sp = 22 + 11 * i;
            if (f[4-i]) begin
                if (s >= sp - 8 && s < sp - 5) lvl = 1'b0;
            end else begin
                if (s >= sp - 8 && s < sp + 2) lvl = 1'b0;
            end
        end
        return lvl;
    endfunction

    task automatic runCycles(input int n, input logic [4:0] f0, input int p0, input logic [4:0] f1, input int p1);
        for (int w = 0; w < 1001 && tsc != 0; w++) begin
            @(posedge clk);
            #1;
        end
        if (tsc != 0) checkVal("align_timeout", tsc, 0);
        for (int t = 0; t < n; t++) begin
            data_line[0] = lineLevel(tsc, f0, p0);
            data_line[1] = lineLevel(tsc, f1, p1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runScans(input int n, input logic [4:0] f0, input int p0, input logic [4:0] f1, input int p1);
        runCycles(n * 1000, f0, p0, f1, p1);
    endtask

    task automatic drainCheck(input string tag);
        checkVal({tag, "_count"}, gotCode.size(), exp_q.size());
        while (gotCode.size() > 0 && exp_q.size() > 0)
            checkVal({tag, "_code"}, gotCode.pop_front(), exp_q.pop_front());
        gotCode.delete();
        gotTsc.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkVal("rst_scan_line", scan_line, 2'b11);
        checkVal("rst_key_state", key_state, 10'h3FF);
        checkVal("rst_evt_valid", evt_valid, 1'b0);
        checkVal("rst_evt_code", evt_code, 8'h00);
        checkVal("rst_frame_err", frame_err, 2'b00);
        checkVal("rst_overflow", overflow, 1'b0);

        evt_ready = 1'b1;
        runScans(3, 5'b11111, 0, 5'b11111, 0);
        checkVal("idle_err", err0Cnt + err1Cnt, 0);
        checkVal("idle_key_state", key_state, 10'h3FF);
        drainCheck("idle");

        exp_q.push_back(8'h67);
        runScans(1, 5'b11110, 5, 5'b11111, 0);
        checkVal("press_early", gotCode.size(), 0);
        runScans(1, 5'b11110, 5, 5'b11111, 0);
        checkVal("press_time", (gotTsc.size() > 0) ? gotTsc[0] : -1, 69);
        drainCheck("press");
        checkVal("press_key_state", key_state, 10'h3FE);

        exp_q.push_back(8'hA7);
        runScans(2, 5'b11111, 0, 5'b11111, 0);
        drainCheck("release");
        checkVal("release_key_state", key_state, 10'h3FF);

        runScans(1, 5'b11110, 5, 5'b11111, 0);
        runScans(1, 5'b11111, 3, 5'b11111, 0);
        checkVal("err_count", err0Cnt, 1);
        checkVal("err_time", err0Tsc, 67);
        checkVal("err_other_ch", err1Cnt, 0);
        runScans(1, 5'b11110, 5, 5'b11111, 0);
        checkVal("err_db_restart", gotCode.size(), 0);
        exp_q.push_back(8'h67);
        runScans(1, 5'b11110, 5, 5'b11111, 0);
        drainCheck("err_then_press");

        evt_ready = 1'b0;
        runScans(2, 5'b00001, 5, 5'b00000, 5);
        checkVal("ovf_set", overflow, 1'b1);
        checkVal("ovf_head_valid", evt_valid, 1'b1);
        checkVal("ovf_head_code", evt_code, 8'hA7);
        repeat (3) @(posedge clk);
        #1;
        checkVal("ovf_head_stable", evt_code, 8'hA7);
        exp_q.push_back(8'hA7);
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h65);
        exp_q.push_back(8'h64);
        evt_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        drainCheck("ovf_drain");
        checkVal("ovf_empty", evt_valid, 1'b0);
        checkVal("ovf_sticky", overflow, 1'b1);
        overflow_clr = 1'b1;
        @(posedge clk);
        #1;
        overflow_clr = 1'b0;
        checkVal("ovf_cleared", overflow, 1'b0);
        checkVal("ovf_key_state", key_state, 10'h001);

        evt_ready = 1'b0;
        runCycles(2040, 5'b11001, 5, 5'b00000, 5);
        checkVal("pre_rst_valid", evt_valid, 1'b1);
        checkVal("pre_rst_code", evt_code, 8'hA4);
        checkVal("pre_rst_key_state", key_state, 10'h019);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        data_line = 2'b11;
        checkVal("mid_rst_valid", evt_valid, 1'b0);
        checkVal("mid_rst_scan_line", scan_line, 2'b11);
        checkVal("mid_rst_key_state", key_state, 10'h3FF);
        checkVal("mid_rst_evt_code", evt_code, 8'h00);
        evt_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkVal("post_rst_strobe", scan_line, 2'b00);
        runScans(1, 5'b11111, 0, 5'b11111, 0);
        checkVal("post_rst_events", gotCode.size(), 0);
        checkVal("post_rst_key_state", key_state, 10'h3FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
